// File: rtl/botones_pkg.sv
// Shared definitions for the button-handling blocks.
//   estado_t       : FSM state type of detector_pulsaciones (fixed encoding)
//   ancho_cnt()    : counter width for a pair of cycle limits
//   *_DEF          : default timing constants for a 50 MHz clock
package botones_pkg;

   // 2'b11 is unused; the detector treats it as an illegal state.
   typedef enum logic [1:0] {
      REPOSO     = 2'b00,
      PRESIONADO = 2'b01,
      LARGO      = 2'b10
   } estado_t;

   localparam int unsigned LARGO_CICLOS_DEF      = 50_000_000; // 1 s
   localparam int unsigned REPETICION_CICLOS_DEF = 10_000_000; // 200 ms

   // The counter only has to reach (limit-1), so clog2(limit) bits are enough.
   // A floor of 1 bit keeps the vector legal when both limits are tiny.
   function automatic int unsigned ancho_cnt(input int unsigned a,
                                             input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/detector_pulsaciones.sv
// Button-event classifier. Turns a debounced button level into one-cycle
// strobes: short press, long press and auto-repeat while held.
// Ports:
//   clk               system clock (rising edge)
//   rst_n             asynchronous active-low reset
//   boton_limpio      debounced button level, active-high
//   presionado        high whenever the FSM is not idle
//   pulso_corto       strobe: released before the long-press threshold
//   pulso_largo       strobe: long-press threshold reached
//   pulso_repeticion  strobe: auto-repeat tick while held after a long press
module detector_pulsaciones
   import botones_pkg::*;
#(
   parameter int unsigned LARGO_CICLOS      = LARGO_CICLOS_DEF,
   parameter int unsigned REPETICION_CICLOS = REPETICION_CICLOS_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic boton_limpio,
   output logic presionado,
   output logic pulso_corto,
   output logic pulso_largo,
   output logic pulso_repeticion
);

   localparam int unsigned CNT_W = ancho_cnt(LARGO_CICLOS, REPETICION_CICLOS);
   localparam logic [CNT_W-1:0] LIM_LARGO = CNT_W'(LARGO_CICLOS - 1);
   localparam logic [CNT_W-1:0] LIM_REP   = CNT_W'(REPETICION_CICLOS - 1);

   if (LARGO_CICLOS < 2) begin : g_chk_largo
      $error("detector_pulsaciones: LARGO_CICLOS must be >= 2");
   end
   if (REPETICION_CICLOS < 1) begin : g_chk_rep
      $error("detector_pulsaciones: REPETICION_CICLOS must be >= 1");
   end

   estado_t          estado_q, estado_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             corto_q, corto_d;
   logic             largo_q, largo_d;
   logic             rep_q, rep_d;

   // In PRESIONADO, cnt holds (j-1) at edge E_j, so the compare against
   // LARGO_CICLOS-1 fires at E_L. Release is tested first so it wins ties.
   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      corto_d  = 1'b0;
      largo_d  = 1'b0;
      rep_d    = 1'b0;
      case (estado_q)
         REPOSO: begin
            if (boton_limpio) begin
               estado_d = PRESIONADO;
               cnt_d    = '0;
            end
         end
         PRESIONADO: begin
            if (!boton_limpio) begin
               corto_d  = 1'b1;
               estado_d = REPOSO;
               cnt_d    = '0;
            end else if (cnt_q == LIM_LARGO) begin
               largo_d  = 1'b1;
               estado_d = LARGO;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LARGO: begin
            if (!boton_limpio) begin
               estado_d = REPOSO;
               cnt_d    = '0;
            end else if (cnt_q == LIM_REP) begin
               rep_d = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            // Illegal encoding: fall back to idle silently.
            estado_d = REPOSO;
            cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= REPOSO;
         cnt_q    <= '0;
         corto_q  <= 1'b0;
         largo_q  <= 1'b0;
         rep_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         corto_q  <= corto_d;
         largo_q  <= largo_d;
         rep_q    <= rep_d;
      end
   end

   // Taken from the state register so it lines up with the pulse flops.
   assign presionado       = (estado_q != REPOSO);
   assign pulso_corto      = corto_q;
   assign pulso_largo      = largo_q;
   assign pulso_repeticion = rep_q;

endmodule

// File: tb/tb_detector_pulsaciones.sv
// Self-checking bench for detector_pulsaciones (LARGO=10, REPETICION=4).
// A press-length reference model predicts outputs one cycle after each edge.
module tb_detector_pulsaciones;

   localparam int L = 10;
   localparam int R = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic boton_limpio = 1'b0;
   logic presionado, pulso_corto, pulso_largo, pulso_repeticion;

   int vectors = 0;
   int miscompares = 0;

   // reference model state: pressed flag and index j of the current edge E_j
   bit m_pulsado = 1'b0;
   int m_j = 0;
   logic [3:0] esp = 4'b0000; // {presionado, corto, largo, repeticion}

   detector_pulsaciones #(.LARGO_CICLOS(L), .REPETICION_CICLOS(R)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .boton_limpio     (boton_limpio),
      .presionado       (presionado),
      .pulso_corto      (pulso_corto),
      .pulso_largo      (pulso_largo),
      .pulso_repeticion (pulso_repeticion)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] obs();
      return {presionado, pulso_corto, pulso_largo, pulso_repeticion};
   endfunction

   task automatic modelo_reset();
      m_pulsado = 1'b0;
      m_j = 0;
      esp = 4'b0000;
   endtask

   // One functional edge: drive, clock, update model, settle at negedge.
   task automatic paso(input logic b);
      logic c, lg, rp;
      boton_limpio = b;
      @(posedge clk);
      c = 1'b0; lg = 1'b0; rp = 1'b0;
      if (!m_pulsado) begin
         if (b) begin m_pulsado = 1'b1; m_j = 0; end
      end else begin
         m_j++;
         if (!b) begin
            c = (m_j <= L);
            m_pulsado = 1'b0;
         end else if (m_j == L) lg = 1'b1;
         else if (m_j > L && ((m_j - L) % R) == 0) rp = 1'b1;
      end
      esp = {m_pulsado, c, lg, rp};
      @(negedge clk);
   endtask

   // never more than one strobe in the same cycle
   always @(negedge clk) begin
      if (rst_n && $countones({pulso_corto, pulso_largo, pulso_repeticion}) > 1) begin
         miscompares++;
         $display("FAIL pulse_overlap t=%0t: got %b required at most one pulse",
                  $time, {pulso_corto, pulso_largo, pulso_repeticion});
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      boton_limpio = 1'b1;
      modelo_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (obs() !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_hold cyc %0d: got %b required 0000", i, obs());
         end
      end
      rst_n = 1'b1;
      paso(1'b1);
      vectors++;
      if (obs() !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_first_edge: got %b required 1000", obs());
      end
      for (int i = 0; i < 3; i++) begin
         paso(1'b0);
         vectors++;
         if (obs() !== esp) begin
            miscompares++;
            $display("FAIL reset_tail %0d: got %b required %b", i, obs(), esp);
         end
      end
   endtask

   task automatic test_short();
      int n_corto = 0;
      for (int i = 0; i < 7; i++) begin
         paso((i < 3) ? 1'b1 : 1'b0);
         vectors++;
         if (obs() !== esp) begin
            miscompares++;
            $display("FAIL short step %0d: got %b required %b", i, obs(), esp);
         end
         if (pulso_corto) n_corto++;
         if (i == 3 && obs() !== 4'b0100) begin
            miscompares++;
            $display("FAIL short_release: got %b required 0100", obs());
         end
      end
      vectors++;
      if (n_corto != 1) begin
         miscompares++;
         $display("FAIL short_count: got %0d required 1", n_corto);
      end
   endtask

   task automatic test_boundary();
      // release exactly at E10
      for (int i = 0; i <= L + 2; i++) begin
         paso((i < L) ? 1'b1 : 1'b0);
         vectors++;
         if (obs() !== esp) begin
            miscompares++;
            $display("FAIL bound_rel step %0d: got %b required %b", i, obs(), esp);
         end
         if (i == L && obs() !== 4'b0100) begin
            miscompares++;
            $display("FAIL bound_rel_E10: got %b required 0100", obs());
         end
      end
      // hold through E10, release at E11
      for (int i = 0; i <= L + 3; i++) begin
         paso((i <= L) ? 1'b1 : 1'b0);
         vectors++;
         if (obs() !== esp) begin
            miscompares++;
            $display("FAIL bound_hold step %0d: got %b required %b", i, obs(), esp);
         end
         if (i == L && obs() !== 4'b1010) begin
            miscompares++;
            $display("FAIL bound_hold_E10: got %b required 1010", obs());
         end
         if (i == L + 1 && obs() !== 4'b0000) begin
            miscompares++;
            $display("FAIL bound_hold_release: got %b required 0000", obs());
         end
      end
   endtask

   task automatic test_autorepeat();
      int n_rep = 0, n_largo = 0;
      for (int i = 0; i <= 27; i++) begin
         paso((i < 25) ? 1'b1 : 1'b0);
         vectors++;
         if (obs() !== esp) begin
            miscompares++;
            $display("FAIL autorep step %0d: got %b required %b", i, obs(), esp);
         end
         if (pulso_repeticion) begin
            n_rep++;
            if (i != 14 && i != 18 && i != 22) begin
               miscompares++;
               $display("FAIL autorep_pos: got repeat after E%0d required E14/E18/E22", i);
            end
         end
         if (pulso_largo) n_largo++;
      end
      vectors++;
      if (n_rep != 3 || n_largo != 1) begin
         miscompares++;
         $display("FAIL autorep_count: got rep=%0d largo=%0d required 3 and 1", n_rep, n_largo);
      end
   endtask

   task automatic test_reset_mid_largo();
      for (int i = 0; i <= 12; i++) paso(1'b1);
      vectors++;
      if (obs() !== esp) begin
         miscompares++;
         $display("FAIL midlargo_pre: got %b required %b", obs(), esp);
      end
      rst_n = 1'b0;
      modelo_reset();
      #1;
      vectors++;
      if (obs() !== 4'b0000) begin
         miscompares++;
         $display("FAIL midlargo_async: got %b required 0000", obs());
      end
      @(negedge clk);
      boton_limpio = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         paso(1'b0);
         vectors++;
         if (obs() !== 4'b0000) begin
            miscompares++;
            $display("FAIL midlargo_after %0d: got %b required 0000", i, obs());
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] patron = 4'b1010; // applied MSB first: 1,0,1,0
      int n_corto = 0;
      for (int i = 0; i < 6; i++) begin
         paso((i < 4) ? patron[3 - i] : 1'b0);
         vectors++;
         if (obs() !== esp) begin
            miscompares++;
            $display("FAIL b2b step %0d: got %b required %b", i, obs(), esp);
         end
         if (pulso_corto) begin
            n_corto++;
            if (i != 1 && i != 3) begin
               miscompares++;
               $display("FAIL b2b_pos: got corto after edge %0d required 1 or 3", i);
            end
         end
      end
      vectors++;
      if (n_corto != 2) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d required 2", n_corto);
      end
   endtask

   task automatic test_random();
      logic b = 1'b0;
      int run;
      for (int k = 0; k < 60; k++) begin
         b = ~b;
         run = (b && ($urandom_range(0, 2) == 0)) ? $urandom_range(9, 30)
                                                  : $urandom_range(1, 6);
         for (int i = 0; i < run; i++) begin
            paso(b);
            vectors++;
            if (obs() !== esp) begin
               miscompares++;
               $display("FAIL random run %0d step %0d: got %b required %b", k, i, obs(), esp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_short();
      test_boundary();
      test_autorepeat();
      test_reset_mid_largo();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
